ham_ber_ctrl: RTL and testbench

Self-test sequencer for the (17,12) Hamming datapath (ham_enc -> ham_dec -> bit_com).
- Generates info words with an LFSR and injects a programmable number of codeword bit errors.
- Runs a requested number of frames and accumulates decoded-bit-error statistics.
- Sits beside top as the BER/self-check controller; results are read by the host after done.

---
 rtl/ham_pkg.sv | 49 ++++
 rtl/bit_com.sv | 10 +
 rtl/ham_dec.sv | 23 ++
 rtl/ham_enc.sv | 15 +
 rtl/ham_lfsr12.sv | 22 ++
 rtl/ham_ber_ctrl.sv | 118 +++++++++++
 tb/tb_ham_ber_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/ham_pkg.sv
// Shared constants for the (17,12) Hamming self-test slice: codeword geometry,
// bit-position tables for the encoder/decoder, the LFSR taps, the controller
// state encoding and the error-injection mask helper.
package ham_pkg;

   localparam int CW_W   = 17;
   localparam int INFO_W = 12;
   localparam int DIS_W  = 4;
   localparam int PAR_W  = 5;

   // Fibonacci feedback taps at stages 12, 11, 10 and 4 (bits 11, 10, 9, 3)
   localparam logic [INFO_W-1:0] LFSR_TAPS = 12'hE08;

   // Codeword index (Hamming position - 1) holding info bit j
   localparam logic [INFO_W-1:0][4:0] DATA_IDX = {5'd16, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10,
                                                  5'd9,  5'd8,  5'd6,  5'd5,  5'd4,  5'd2};

   // Info bits covered by parity bit k (stored at codeword index 2**k - 1)
   localparam logic [PAR_W-1:0][INFO_W-1:0] PAR_MASK = {12'h800, 12'h7F0, 12'h78E,
                                                        12'h66D, 12'hD5B};

   // Codeword bits whose Hamming position has bit k set (syndrome bit k)
   localparam logic [PAR_W-1:0][CW_W-1:0] SYN_MASK = {17'h18000, 17'h07F80, 17'h07878,
                                                      17'h06666, 17'h15555};

   // Controller states
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_GEN  = 3'd1;
   localparam state_t ST_INJ  = 3'd2;
   localparam state_t ST_CMP  = 3'd3;
   localparam state_t ST_FIN  = 3'd4;

   // Up to three adjacent flipped bits starting at pos, wrapping modulo CW_W
   function automatic logic [CW_W-1:0] err_mask(input logic [4:0] pos,
                                                input logic [1:0] weight);
      logic [2:0]        pat;
      logic [2*CW_W-1:0] wide;
      case (weight)
         2'd0:    pat = 3'b000;
         2'd1:    pat = 3'b001;
         2'd2:    pat = 3'b011;
         default: pat = 3'b111;
      endcase
      wide = {{(2*CW_W-3){1'b0}}, pat} << pos;
      return wide[CW_W-1:0] | wide[2*CW_W-1:CW_W];
   endfunction

endpackage

// File: rtl/bit_com.sv
// Hamming distance between transmitted and decoded info words.
module bit_com import ham_pkg::*; (
   input  logic [INFO_W-1:0] a,
   input  logic [INFO_W-1:0] b,
   output logic [DIS_W-1:0]  dis
);

   assign dis = DIS_W'($countones(a ^ b));

endmodule

// File: rtl/ham_dec.sv
// (17,12) Hamming single-error-correcting decoder. Syndromes above 17 point
// outside the shortened code and leave the word untouched.
module ham_dec import ham_pkg::*; (
   input  logic [CW_W-1:0]   cw,
   output logic [INFO_W-1:0] info
);

   logic [PAR_W-1:0] syn;
   logic [CW_W-1:0]  fix;

   for (genvar gi = 0; gi < PAR_W; gi++) begin : g_syn
      assign syn[gi] = ^(cw & SYN_MASK[gi]);
   end

   for (genvar gi = 0; gi < CW_W; gi++) begin : g_fix
      assign fix[gi] = cw[gi] ^ (syn == 5'(gi + 1));
   end

   for (genvar gi = 0; gi < INFO_W; gi++) begin : g_out
      assign info[gi] = fix[DATA_IDX[gi]];
   end

endmodule

// File: rtl/ham_enc.sv
// (17,12) Hamming encoder: parity bits at positions 1,2,4,8,16, data elsewhere.
module ham_enc import ham_pkg::*; (
   input  logic [INFO_W-1:0] info,
   output logic [CW_W-1:0]   cw
);

   for (genvar gi = 0; gi < INFO_W; gi++) begin : g_data
      assign cw[DATA_IDX[gi]] = info[gi];
   end

   for (genvar gi = 0; gi < PAR_W; gi++) begin : g_par
      assign cw[(1 << gi) - 1] = ^(info & PAR_MASK[gi]);
   end

endmodule

// File: rtl/ham_lfsr12.sv
// 12-bit Fibonacci LFSR producing self-test info words; load returns it to SEED.
module ham_lfsr12 import ham_pkg::*; #(
   parameter logic [INFO_W-1:0] SEED = 12'hACE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   output logic [INFO_W-1:0] state
);

   // Reload has priority over stepping; feedback enters at the LSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= SEED;
      else if (load)
         state <= SEED;
      else if (step)
         state <= {state[INFO_W-2:0], ^(state & LFSR_TAPS)};
   end

endmodule

// File: rtl/ham_ber_ctrl.sv
// BER self-test sequencer around ham_enc -> ham_dec -> bit_com.
// Each frame takes GEN (draw info word), INJ (encode + inject errors) and
// CMP (decode, compare, accumulate). Results hold in IDLE until the next start.
// Optional build macro HAM_BER_ABORT_EN adds an abort input that ends a run early.
module ham_ber_ctrl import ham_pkg::*; #(
   parameter int                FRAME_W = 16,
   parameter int                ERR_W   = 24,
   parameter logic [INFO_W-1:0] SEED    = 12'hACE
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [FRAME_W-1:0] num_frames,
   input  logic [1:0]         err_weight,
`ifdef HAM_BER_ABORT_EN
   input  logic               abort,
`endif
   output logic               busy,
   output logic               done,
   output logic [FRAME_W-1:0] frames_run,
   output logic [FRAME_W-1:0] err_frames,
   output logic [ERR_W-1:0]   bit_err_total
);

   state_t             state_reg;
   logic [FRAME_W-1:0] num_reg;
   logic [1:0]         weight_reg;
   logic [4:0]         pos_reg;
   logic [INFO_W-1:0]  info_reg;
   logic [CW_W-1:0]    cw_reg;

   logic [INFO_W-1:0]  lfsr_state;
   logic [CW_W-1:0]    cw_enc;
   logic [INFO_W-1:0]  dec_info;
   logic [DIS_W-1:0]   ham_dis;
   logic [ERR_W:0]     err_sum;
   logic               abort_hit;
   logic               start_ok;

`ifdef HAM_BER_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   assign start_ok = (state_reg == ST_IDLE) && start;
   assign err_sum  = {1'b0, bit_err_total} + {{(ERR_W+1-DIS_W){1'b0}}, ham_dis};

   ham_lfsr12 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (start_ok),
      .step  (state_reg == ST_GEN),
      .state (lfsr_state)
   );

   ham_enc u_enc (.info(info_reg), .cw(cw_enc));
   ham_dec u_dec (.cw(cw_reg), .info(dec_info));
   bit_com u_com (.a(info_reg), .b(dec_info), .dis(ham_dis));

   // Run sequencer: latches the request, steps frames, accumulates statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         num_reg       <= '0;
         weight_reg    <= '0;
         pos_reg       <= '0;
         info_reg      <= '0;
         cw_reg        <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         frames_run    <= '0;
         err_frames    <= '0;
         bit_err_total <= '0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  num_reg       <= num_frames;
                  weight_reg    <= err_weight;
                  pos_reg       <= '0;
                  frames_run    <= '0;
                  err_frames    <= '0;
                  bit_err_total <= '0;
                  busy          <= 1'b1;
                  state_reg     <= (num_frames == '0) ? ST_FIN : ST_GEN;
               end
            end
            ST_GEN: begin
               info_reg  <= lfsr_state;
               state_reg <= abort_hit ? ST_FIN : ST_INJ;
            end
            ST_INJ: begin
               cw_reg    <= cw_enc ^ err_mask(pos_reg, weight_reg);
               state_reg <= abort_hit ? ST_FIN : ST_CMP;
            end
            ST_CMP: begin
               bit_err_total <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
               err_frames    <= err_frames + {{(FRAME_W-1){1'b0}}, (ham_dis != '0)};
               frames_run    <= frames_run + FRAME_W'(1);
               pos_reg       <= (pos_reg == 5'd16) ? 5'd0 : pos_reg + 5'd1;
               if (abort_hit || (frames_run + FRAME_W'(1) == num_reg))
                  state_reg <= ST_FIN;
               else
                  state_reg <= ST_GEN;
            end
            ST_FIN: begin
               done      <= 1'b1;
               busy      <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ham_ber_ctrl.sv
// Self-checking bench for ham_ber_ctrl. A transaction-level model predicts,
// for every cycle, busy/done and the running counters from the run request,
// the LFSR sequence and a position-arithmetic Hamming code.
module tb_ham_ber_ctrl;

   localparam int          FRAME_W = 16;
   localparam int          ERR_W   = 24;
   localparam logic [11:0] SEED    = 12'hACE;
   localparam int          MAXF    = 64;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [FRAME_W-1:0] num_frames = '0;
   logic [1:0]         err_weight = '0;
`ifdef HAM_BER_ABORT_EN
   logic               abort = 1'b0;
`endif
   logic               busy;
   logic               done;
   logic [FRAME_W-1:0] frames_run;
   logic [FRAME_W-1:0] err_frames;
   logic [ERR_W-1:0]   bit_err_total;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   int     cyc = 0;
   bit     m_has = 1'b0;
   int     m_start = 0;
   int     m_fin_t = 0;
   int     m_nf = 0;
   int     cum_ef [0:MAXF];
   longint cum_bt [0:MAXF];

   ham_ber_ctrl #(.FRAME_W(FRAME_W), .ERR_W(ERR_W), .SEED(SEED)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .num_frames    (num_frames),
      .err_weight    (err_weight),
`ifdef HAM_BER_ABORT_EN
      .abort         (abort),
`endif
      .busy          (busy),
      .done          (done),
      .frames_run    (frames_run),
      .err_frames    (err_frames),
      .bit_err_total (bit_err_total)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] m_lfsr_next(input logic [11:0] s);
      return {s[10:0], s[11] ^ s[10] ^ s[9] ^ s[3]};
   endfunction

   // Hamming position p (1..17) lives at codeword bit p-1
   function automatic logic [16:0] m_enc(input logic [11:0] d);
      logic [16:0] c;
      int j;
      int s;
      c = '0;
      j = 0;
      for (int p = 1; p <= 17; p++)
         if ((p & (p - 1)) != 0) begin
            c[p-1] = d[j];
            j++;
         end
      s = 0;
      for (int p = 1; p <= 17; p++)
         if (c[p-1]) s = s ^ p;
      for (int k = 0; k < 5; k++)
         if (s[k]) c[(1 << k) - 1] = 1'b1;
      return c;
   endfunction

   function automatic logic [11:0] m_dec(input logic [16:0] cw);
      logic [16:0] c;
      logic [11:0] d;
      int s;
      int j;
      c = cw;
      s = 0;
      for (int p = 1; p <= 17; p++)
         if (c[p-1]) s = s ^ p;
      if (s >= 1 && s <= 17) c[s-1] = ~c[s-1];
      d = '0;
      j = 0;
      for (int p = 1; p <= 17; p++)
         if ((p & (p - 1)) != 0) begin
            d[j] = c[p-1];
            j++;
         end
      return d;
   endfunction

   // Cumulative per-frame statistics for a run of n frames at weight w
   function automatic void m_build(input int n, input int w);
      logic [11:0] s;
      logic [16:0] mask;
      int pos;
      int dis;
      s = SEED;
      pos = 0;
      cum_ef[0] = 0;
      cum_bt[0] = 0;
      for (int k = 0; k < n && k < MAXF; k++) begin
         mask = '0;
         for (int i = 0; i < w; i++) mask[(pos + i) % 17] = 1'b1;
         dis = $countones(s ^ m_dec(m_enc(s) ^ mask));
         cum_ef[k+1] = cum_ef[k] + ((dis != 0) ? 1 : 0);
         cum_bt[k+1] = cum_bt[k] + dis;
         if (cum_bt[k+1] > (longint'(1) << ERR_W) - 1) cum_bt[k+1] = (longint'(1) << ERR_W) - 1;
         s = m_lfsr_next(s);
         pos = (pos + 1) % 17;
      end
   endfunction

   // Model: tracks accepted runs (and aborts) at each rising edge
   initial forever begin : model_proc
      int tp;
      @(posedge clk);
      cyc = cyc + 1;
      if (!rst_n) begin
         m_has = 1'b0;
      end else begin
         tp = cyc - 1 - m_start;
`ifdef HAM_BER_ABORT_EN
         if (m_has && abort && tp >= 0 && tp < m_fin_t) begin
            m_fin_t = tp + 1;
            m_nf = (tp % 3 == 2) ? tp / 3 + 1 : tp / 3;
         end
`endif
         if (start && (!m_has || tp >= m_fin_t + 1)) begin
            m_has = 1'b1;
            m_start = cyc;
            m_nf = int'(num_frames);
            m_fin_t = 3 * m_nf;
            m_build(m_nf, int'(err_weight));
         end
      end
   end

   // Compare: every falling edge, DUT outputs against the model's prediction
   initial forever begin : cmp_proc
      int t;
      int f;
      logic   e_busy;
      logic   e_done;
      longint e_fr;
      longint e_ef;
      longint e_bt;
      @(negedge clk);
      if (!rst_n || !m_has) begin
         e_busy = 1'b0; e_done = 1'b0; e_fr = 0; e_ef = 0; e_bt = 0;
      end else begin
         t = cyc - m_start;
         f = t / 3;
         if (f > m_nf) f = m_nf;
         if (f > MAXF) f = MAXF;
         e_busy = (t <= m_fin_t);
         e_done = (t == m_fin_t + 1);
         e_fr = f;
         e_ef = cum_ef[f];
         e_bt = cum_bt[f];
      end
      chk("cyc_busy", busy, e_busy);
      chk("cyc_done", done, e_done);
      chk("cyc_frames_run", frames_run, e_fr);
      chk("cyc_err_frames", err_frames, e_ef);
      chk("cyc_bit_err_total", bit_err_total, e_bt);
   end

   task automatic kick(input int n, input int w);
      @(posedge clk); #1;
      start = 1'b1;
      num_frames = n[FRAME_W-1:0];
      err_weight = w[1:0];
      @(posedge clk); #1;
      start = 1'b0;
      num_frames = FRAME_W'($urandom);
      err_weight = 2'($urandom);
   endtask

   // Start a run and wait (bounded) for done; lat counts edges from the edge
   // that samples start to the first edge that samples done high
   task automatic run(input int n, input int w, input bit poke, output int lat);
      int k;
      kick(n, w);
      k = 0;
      while (!done && k < 3 * n + 20) begin
         @(posedge clk); #1;
         k++;
         start = poke && (k == 4 || k == 11 || k == 20) && (k < 3 * n);
         if (start) num_frames = FRAME_W'($urandom_range(1, 5));
      end
      start = 1'b0;
      chk("done_seen", done, 1'b1);
      lat = k + 1;
      $display("[TB] run n=%0d w=%0d poke=%0d latency=%0d frames_run=%0d err_frames=%0d bit_err_total=%0d",
               n, w, poke, lat, frames_run, err_frames, bit_err_total);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no end of run, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int lat;
      int n;
      int w;
      int k;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_frames_run", frames_run, 0);
      chk("reset_err_frames", err_frames, 0);
      chk("reset_bit_err_total", bit_err_total, 0);

      // hand-derived anchors for the model itself
      chk("model_lfsr_step", m_lfsr_next(12'hACE), 12'h59D);
      chk("model_enc_bit0", m_enc(12'h001), 17'h00007);
      chk("model_enc_bit11", m_enc(12'h800), 17'h18001);
      chk("model_dec_single", m_dec(m_enc(12'h5A3) ^ 17'h00100), 12'h5A3);
      chk("model_dec_double", m_dec(17'h00003), 12'h001);

      run(20, 0, 1'b0, lat);
      chk("n20_latency", lat, 62);
      chk("n20_frames_run", frames_run, 20);
      chk("n20_err_frames", err_frames, 0);
      chk("n20_bit_err_total", bit_err_total, 0);

      run(34, 1, 1'b0, lat);
      chk("n34_latency", lat, 104);
      chk("n34_frames_run", frames_run, 34);
      chk("n34_err_frames", err_frames, 0);
      chk("n34_bit_err_total", bit_err_total, 0);

      run(17, 2, 1'b0, lat);
      chk("n17_frames_run", frames_run, 17);
      chk("n17_err_frames", err_frames, cum_ef[17]);
      chk("n17_bit_err_total", bit_err_total, cum_bt[17]);
      chk("n17_err_frames_nonzero", err_frames != 0, 1'b1);

      run(0, 3, 1'b0, lat);
      chk("n0_latency", lat, 2);
      chk("n0_frames_run", frames_run, 0);
      chk("n0_bit_err_total", bit_err_total, 0);

      run(10, 3, 1'b1, lat);
      chk("restart_ignored_latency", lat, 32);
      chk("restart_ignored_frames_run", frames_run, 10);

      // reset during frame 5
      kick(12, 1);
      repeat (13) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_busy", busy, 1'b0);
      chk("midreset_frames_run", frames_run, 0);
      chk("midreset_err_frames", err_frames, 0);
      chk("midreset_bit_err_total", bit_err_total, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run(3, 2, 1'b0, lat);
      chk("after_reset_latency", lat, 11);
      chk("after_reset_frames_run", frames_run, 3);

`ifdef HAM_BER_ABORT_EN
      kick(10, 1);
      repeat (9) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      k = 0;
      while (!done && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      chk("abort_done_seen", done, 1'b1);
      chk("abort_frames_run", frames_run, 3);
      $display("[TB] abort run n=10 frames_run=%0d", frames_run);
`endif

      for (int i = 0; i < 8; i++) begin
         n = $urandom_range(0, 40);
         w = $urandom_range(0, 3);
         run(n, w, 1'($urandom_range(0, 1)), lat);
         chk("rand_latency", lat, 3 * n + 2);
         chk("rand_frames_run", frames_run, n);
         chk("rand_bit_err_total", bit_err_total, cum_bt[n]);
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
